// File: rtl/pwm_multi_pkg.sv
// Shared constants and types for the multi-channel PWM: default sizes,
// the counting-mode enum and a default-width count type.
package pwm_multi_pkg;

    localparam int PWM_WIDTH    = 8;
    localparam int PWM_CHANNELS = 4;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef logic [PWM_WIDTH-1:0] pwm_count_t;

endpackage

// File: rtl/pwm_cmp_channel.sv
// One PWM compare channel: a shadow duty register loaded on the period
// reload strobe, compared against the shared counter.
module pwm_cmp_channel
    import pwm_multi_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reload,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    output logic             out
);

    logic [WIDTH-1:0] duty_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            duty_q <= '0;
        end else if (reload) begin
            duty_q <= duty;
        end
    end

    // Count 0 means idle; duty at or above the period keeps the output high.
    assign out = en && (count != '0) && (count <= duty_q);

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with one shared period counter, shadowed period/duty/mode
// and optional center-aligned counting. Optional macro PWM_MULTI_PERIOD_IRQ_EN
// adds the io_periodEnd strobe.
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int CHANNELS = PWM_CHANNELS
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      io_en,
    input  logic [WIDTH-1:0]          io_periodCounter,
    input  logic [CHANNELS*WIDTH-1:0] io_dutyCicle,
    input  logic                      io_center,
    output logic [CHANNELS-1:0]       io_out,
    output logic [WIDTH-1:0]          io_contador,
    output logic                      io_dir
`ifdef PWM_MULTI_PERIOD_IRQ_EN
    ,
    output logic                      io_periodEnd
`endif
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    pwm_mode_e        mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             center_run;
    logic             end_of_period;
    logic             reload;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            dir_q    <= 1'b1;
            period_q <= '0;
            mode_q   <= PWM_EDGE;
        end else begin
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            mode_q   <= mode_d;
        end
    end

    // The down phase stops at 2: the next period's count 1 doubles as the
    // final down step, giving 2P-2 clocks per center-aligned period.
    always_comb begin
        center_run = (mode_q == PWM_CENTER) && (period_q >= WIDTH'(2));
        if (center_run) begin
            end_of_period = (cnt_q == WIDTH'(2)) && (!dir_q || period_q == WIDTH'(2));
        end else begin
            end_of_period = (cnt_q == period_q);
        end
        reload = io_en && ((cnt_q == '0) || end_of_period);
    end

    // Next-state logic
    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        period_d = period_q;
        mode_d   = mode_q;
        if (!io_en) begin
            cnt_d = '0;
            dir_d = 1'b1;
        end else if (reload) begin
            period_d = io_periodCounter;
            mode_d   = pwm_mode_e'(io_center);
            // A zero period parks the counter at 0 so a reload is retried next cycle.
            cnt_d    = (io_periodCounter == '0) ? '0 : WIDTH'(1);
            dir_d    = 1'b1;
        end else if (center_run && !dir_q) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else if (center_run && (cnt_q == period_q)) begin
            cnt_d = cnt_q - WIDTH'(1);
            dir_d = 1'b0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Output logic
    always_comb begin
        io_contador = cnt_q;
        io_dir      = dir_q;
`ifdef PWM_MULTI_PERIOD_IRQ_EN
        io_periodEnd = reload && !reset;
`endif
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_cmp_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clock (clock),
            .reset (reset),
            .reload(reload),
            .duty  (io_dutyCicle[i*WIDTH +: WIDTH]),
            .count (cnt_q),
            .en    (io_en),
            .out   (io_out[i])
        );
    end

endmodule
